// File: rtl/queue_2x111.sv
// Control stage for a 2-entry ready/valid FIFO whose storage is the external ram_2x111 macro.
// Owns the pointers, full/empty tracking, occupancy count and the optional flow/pipe bypasses.
module queue_2x111 #(
  parameter int WIDTH = 111,
  parameter bit FLOW  = 1'b0,
  parameter bit PIPE  = 1'b0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             io_enq_valid,
  output logic             io_enq_ready,
  input  logic [WIDTH-1:0] io_enq_bits,
  output logic             io_deq_valid,
  input  logic             io_deq_ready,
  output logic [WIDTH-1:0] io_deq_bits,
  output logic [1:0]       io_count,
  output logic             ram_W0_addr,
  output logic             ram_W0_en,
  output logic [WIDTH-1:0] ram_W0_data,
  output logic             ram_R0_addr,
  output logic             ram_R0_en,
  input  logic [WIDTH-1:0] ram_R0_data
);

  // Handshake contract: a word moves on a port in every cycle where valid and ready are
  // both high at the rising clock edge; valid never depends on ready of the same port.

  logic enq_ptr_q, enq_ptr_d;
  logic deq_ptr_q, deq_ptr_d;
  logic maybe_full_q, maybe_full_d;

  logic ptr_match, empty, full, bypass, bypass_take;
  logic do_enq, do_deq;

  always_comb begin
    ptr_match = (enq_ptr_q == deq_ptr_q);
    empty     = ptr_match & ~maybe_full_q;
    full      = ptr_match & maybe_full_q;
    bypass    = FLOW & empty;
  end

  // When the bypass hands the word straight to the consumer, nothing touches storage.
  always_comb begin
    bypass_take  = bypass & io_deq_ready;
    io_enq_ready = ~full | (PIPE & io_deq_ready);
    io_deq_valid = bypass ? io_enq_valid : ~empty;
    io_deq_bits  = bypass ? io_enq_bits : ram_R0_data;
    do_enq       = io_enq_ready & io_enq_valid & ~bypass_take;
    do_deq       = io_deq_ready & io_deq_valid & ~bypass_take;
    io_count     = full ? 2'd2 : {1'b0, enq_ptr_q ^ deq_ptr_q};
  end

  always_comb begin
    ram_W0_en   = do_enq;
    ram_W0_addr = enq_ptr_q;
    ram_W0_data = io_enq_bits;
    ram_R0_en   = 1'b1;
    ram_R0_addr = deq_ptr_q;
  end

  always_comb begin
    enq_ptr_d    = enq_ptr_q ^ do_enq;
    deq_ptr_d    = deq_ptr_q ^ do_deq;
    maybe_full_d = maybe_full_q;
    if (do_enq != do_deq) begin
      maybe_full_d = do_enq;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      enq_ptr_q    <= 1'b0;
      deq_ptr_q    <= 1'b0;
      maybe_full_q <= 1'b0;
    end else begin
      enq_ptr_q    <= enq_ptr_d;
      deq_ptr_q    <= deq_ptr_d;
      maybe_full_q <= maybe_full_d;
    end
  end

endmodule

// File: tb/tb_queue_2x111.sv
// Bench for queue_2x111: base, FLOW and PIPE instances share stimulus, each with its own
// 2x111 RAM model and an occupancy-list reference model.
module tb_queue_2x111;
  localparam int W = 111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         enq_valid, deq_ready;
  logic [W-1:0] enq_bits;

  logic         enq_ready [3];
  logic         deq_valid [3];
  logic [W-1:0] deq_bits  [3];
  logic [1:0]   count     [3];
  logic         w0_addr   [3];
  logic         w0_en     [3];
  logic [W-1:0] w0_data   [3];
  logic         r0_addr   [3];
  logic         r0_en     [3];
  logic [W-1:0] r0_data   [3];
  logic [W-1:0] ram       [3][2];

  queue_2x111 #(.WIDTH(W), .FLOW(1'b0), .PIPE(1'b0)) u_base (
    .clock(clk), .reset_n(rst_n),
    .io_enq_valid(enq_valid), .io_enq_ready(enq_ready[0]), .io_enq_bits(enq_bits),
    .io_deq_valid(deq_valid[0]), .io_deq_ready(deq_ready), .io_deq_bits(deq_bits[0]),
    .io_count(count[0]),
    .ram_W0_addr(w0_addr[0]), .ram_W0_en(w0_en[0]), .ram_W0_data(w0_data[0]),
    .ram_R0_addr(r0_addr[0]), .ram_R0_en(r0_en[0]), .ram_R0_data(r0_data[0]));

  queue_2x111 #(.WIDTH(W), .FLOW(1'b1), .PIPE(1'b0)) u_flow (
    .clock(clk), .reset_n(rst_n),
    .io_enq_valid(enq_valid), .io_enq_ready(enq_ready[1]), .io_enq_bits(enq_bits),
    .io_deq_valid(deq_valid[1]), .io_deq_ready(deq_ready), .io_deq_bits(deq_bits[1]),
    .io_count(count[1]),
    .ram_W0_addr(w0_addr[1]), .ram_W0_en(w0_en[1]), .ram_W0_data(w0_data[1]),
    .ram_R0_addr(r0_addr[1]), .ram_R0_en(r0_en[1]), .ram_R0_data(r0_data[1]));

  queue_2x111 #(.WIDTH(W), .FLOW(1'b0), .PIPE(1'b1)) u_pipe (
    .clock(clk), .reset_n(rst_n),
    .io_enq_valid(enq_valid), .io_enq_ready(enq_ready[2]), .io_enq_bits(enq_bits),
    .io_deq_valid(deq_valid[2]), .io_deq_ready(deq_ready), .io_deq_bits(deq_bits[2]),
    .io_count(count[2]),
    .ram_W0_addr(w0_addr[2]), .ram_W0_en(w0_en[2]), .ram_W0_data(w0_data[2]),
    .ram_R0_addr(r0_addr[2]), .ram_R0_en(r0_en[2]), .ram_R0_data(r0_data[2]));

  // ram_2x111 behaviour: synchronous write, combinational read.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (w0_en[k]) ram[k][w0_addr[k]] <= w0_data[k];
    end
  end

  always_comb begin
    for (int k = 0; k < 3; k++) r0_data[k] = ram[k][r0_addr[k]];
  end

  // ---------------- scoreboard / reference model ----------------
  int n_pass = 0;
  int n_total = 0;

  logic [W-1:0] exp_q [3][2];  // queued words per instance, head at index 0
  int           mdl_cnt [3];
  int           mdl_enq_n [3];
  int           mdl_deq_n [3];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      mdl_cnt[k] = 0;
      mdl_enq_n[k] = 0;
      mdl_deq_n[k] = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    enq_bits = '0;
    model_clear();
    tick();
    tick();
    check("reset enq_ready", 128'(enq_ready[0]), 128'd1);
    check("reset deq_valid", 128'(deq_valid[0]), 128'd0);
    check("reset count", 128'(count[0]), 128'd0);
    check("reset r0_en", 128'(r0_en[0]), 128'd1);
    check("reset w0_en", 128'(w0_en[0]), 128'd0);
    rst_n = 1'b1;
  endtask

  // Checks instance k against the model for the inputs currently driven, then
  // advances that model by one clock edge.
  task automatic model_step(input int k);
    bit f, p, emp, full, e_rdy, e_dv, take, de, dd;
    logic [W-1:0] e_bits;
    f = (k == 1);
    p = (k == 2);
    emp = (mdl_cnt[k] == 0);
    full = (mdl_cnt[k] == 2);
    e_rdy = !full || (p && deq_ready);
    e_dv = (f && emp) ? enq_valid : !emp;
    e_bits = (f && emp) ? enq_bits : exp_q[k][0];
    take = f && emp && deq_ready;
    de = !take && e_rdy && enq_valid;
    dd = !take && deq_ready && e_dv;
    check($sformatf("rnd%0d enq_ready", k), 128'(enq_ready[k]), 128'(e_rdy));
    check($sformatf("rnd%0d deq_valid", k), 128'(deq_valid[k]), 128'(e_dv));
    if (e_dv) check($sformatf("rnd%0d deq_bits", k), 128'(deq_bits[k]), 128'(e_bits));
    check($sformatf("rnd%0d count", k), 128'(count[k]), 128'(mdl_cnt[k]));
    check($sformatf("rnd%0d w0_en", k), 128'(w0_en[k]), 128'(de));
    check($sformatf("rnd%0d r0_addr", k), 128'(r0_addr[k]), 128'(mdl_deq_n[k] % 2));
    if (de) begin
      check($sformatf("rnd%0d w0_addr", k), 128'(w0_addr[k]), 128'(mdl_enq_n[k] % 2));
      check($sformatf("rnd%0d w0_data", k), 128'(w0_data[k]), 128'(enq_bits));
    end
    if (dd) begin
      exp_q[k][0] = exp_q[k][1];
      mdl_cnt[k]--;
      mdl_deq_n[k]++;
    end
    if (de) begin
      exp_q[k][mdl_cnt[k]] = enq_bits;
      mdl_cnt[k]++;
      mdl_enq_n[k]++;
    end
  endtask

  // ---------------- directed vector table (base instance) ----------------
  typedef struct {
    logic       ev;
    logic       dr;
    logic [7:0] bits;
    logic       rdy;
    logic       dv;
    logic       chk;
    logic [7:0] dbits;
    logic [1:0] cnt;
    logic       w0en;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic ev, input logic dr, input logic [7:0] bits,
                         input logic rdy, input logic dv, input logic chk,
                         input logic [7:0] dbits, input logic [1:0] cnt, input logic w0en);
    vec_t v;
    v.ev = ev; v.dr = dr; v.bits = bits; v.rdy = rdy; v.dv = dv;
    v.chk = chk; v.dbits = dbits; v.cnt = cnt; v.w0en = w0en;
    vecs.push_back(v);
  endtask

  initial begin
    logic [127:0] r;

    // fill to full, refused third write, drain
    add_vec(1, 0, 8'h01, 1, 0, 0, 8'h00, 2'd0, 1);
    add_vec(1, 0, 8'h02, 1, 1, 1, 8'h01, 2'd1, 1);
    add_vec(1, 0, 8'h03, 0, 1, 1, 8'h01, 2'd2, 0);
    add_vec(0, 1, 8'h00, 0, 1, 1, 8'h01, 2'd2, 0);
    add_vec(0, 1, 8'h00, 1, 1, 1, 8'h02, 2'd1, 0);
    add_vec(0, 0, 8'h00, 1, 0, 0, 8'h00, 2'd0, 0);
    // occupancy 1, then six simultaneous enq+deq of 0xA..0xF
    add_vec(1, 0, 8'h09, 1, 0, 0, 8'h00, 2'd0, 1);
    for (int i = 0; i < 6; i++) add_vec(1, 1, 8'(8'h0A + i), 1, 1, 1, 8'(8'h09 + i), 2'd1, 1);
    add_vec(0, 1, 8'h00, 1, 1, 1, 8'h0F, 2'd1, 0);
    add_vec(0, 0, 8'h00, 1, 0, 0, 8'h00, 2'd0, 0);

    do_reset();
    foreach (vecs[i]) begin
      enq_valid = vecs[i].ev;
      deq_ready = vecs[i].dr;
      enq_bits = W'(vecs[i].bits);
      #2;
      check($sformatf("vec%0d enq_ready", i), 128'(enq_ready[0]), 128'(vecs[i].rdy));
      check($sformatf("vec%0d deq_valid", i), 128'(deq_valid[0]), 128'(vecs[i].dv));
      if (vecs[i].chk) check($sformatf("vec%0d deq_bits", i), 128'(deq_bits[0]), 128'(vecs[i].dbits));
      check($sformatf("vec%0d count", i), 128'(count[0]), 128'(vecs[i].cnt));
      check($sformatf("vec%0d w0_en", i), 128'(w0_en[0]), 128'(vecs[i].w0en));
      tick();
    end

    // FLOW bypass while empty
    do_reset();
    enq_valid = 1'b1; enq_bits = W'(8'h55); deq_ready = 1'b1;
    #2;
    check("flow deq_valid", 128'(deq_valid[1]), 128'd1);
    check("flow deq_bits", 128'(deq_bits[1]), 128'h55);
    check("flow w0_en", 128'(w0_en[1]), 128'd0);
    check("flow count", 128'(count[1]), 128'd0);
    tick();
    enq_valid = 1'b0; deq_ready = 1'b0;
    #2;
    check("flow count after", 128'(count[1]), 128'd0);
    check("flow deq_valid after", 128'(deq_valid[1]), 128'd0);

    // PIPE pass-through while full
    do_reset();
    enq_valid = 1'b1; enq_bits = W'(8'h11); tick();
    enq_bits = W'(8'h22); tick();
    enq_bits = W'(8'h33); deq_ready = 1'b1;
    #2;
    check("pipe enq_ready", 128'(enq_ready[2]), 128'd1);
    check("pipe w0_en", 128'(w0_en[2]), 128'd1);
    check("pipe deq_bits", 128'(deq_bits[2]), 128'h11);
    check("pipe count", 128'(count[2]), 128'd2);
    check("base full enq_ready", 128'(enq_ready[0]), 128'd0);
    tick();
    enq_valid = 1'b0; deq_ready = 1'b0;
    #2;
    check("pipe count after", 128'(count[2]), 128'd2);
    check("pipe head after", 128'(deq_bits[2]), 128'h22);
    deq_ready = 1'b1; tick();
    #2;
    check("pipe last", 128'(deq_bits[2]), 128'h33);

    // asynchronous reset between edges at occupancy 1
    do_reset();
    enq_valid = 1'b1; enq_bits = W'(8'h77); tick();
    enq_valid = 1'b0;
    #2;
    check("pre-reset count", 128'(count[0]), 128'd1);
    rst_n = 1'b0;
    #1;
    check("async count", 128'(count[0]), 128'd0);
    check("async deq_valid", 128'(deq_valid[0]), 128'd0);
    check("async enq_ready", 128'(enq_ready[0]), 128'd1);
    tick();

    // randomized traffic against the reference model
    do_reset();
    for (int c = 0; c < 400; c++) begin
      enq_valid = 1'($urandom_range(0, 1));
      deq_ready = 1'($urandom_range(0, 3) != 0);
      r = {$urandom, $urandom, $urandom, $urandom};
      enq_bits = r[W-1:0];
      #2;
      for (int k = 0; k < 3; k++) model_step(k);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
